// File: rtl/ram_ctrl.sv
// ram_ctrl: load/store sequencer between the memory stage and a byte-lane data RAM.
//   MISALIGN_EN : 1 = split misaligned H/W into two word accesses, 0 = reject them
//   req_*       : valid/ready request (we, funct3 mode, byte addr, right-aligned wdata)
//   rsp_*       : one-cycle response pulse with extended load data and error flag
//   ram_*       : word address, per-lane write enables, read strobe, lane data, read data
module ram_ctrl #(
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [29:0] ram_addr,
    output logic [3:0]  ram_we,
    output logic        ram_re,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);
    typedef enum logic [2:0] {IDLE, ACC0, ACC1, FIN, RESP} state_t;
    state_t      state_q, state_d;
    logic        we_q, split_q, err_q;
    logic [2:0]  mode_q;
    logic [31:0] addr_q, wdata_q, lo_q, rdata_q;
    logic        accept, legal_mode, split_req, illegal;
    logic [2:0]  wb_req;
    logic [1:0]  off;
    logic [3:0]  mask;
    logic [7:0]  mask8;
    logic [63:0] w64;
    logic [31:0] hi, lo, sh, ext;
    logic        sgn, acc0, acc1;

    // request decode, evaluated on the live inputs at the handshake
    assign accept     = req_valid && req_ready;
    assign wb_req     = req_mode[1:0] == 2'b00 ? 3'd1 : req_mode[1:0] == 2'b01 ? 3'd2 : 3'd4;
    assign legal_mode = (req_mode inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) && !(req_we && req_mode[2]);
    assign split_req  = ({1'b0, req_addr[1:0]} + wb_req) > 3'd4;
    assign illegal    = !legal_mode || (split_req && !MISALIGN_EN);

    // store lanes: an 8-lane window across the two words, low half in ACC0, high half in ACC1
    assign off   = addr_q[1:0];
    assign mask  = mode_q[1:0] == 2'b00 ? 4'b0001 : mode_q[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
    assign mask8 = {4'b0000, mask} << off;
    assign w64   = {32'b0, wdata_q} << {off, 3'b000};
    assign acc0  = state_q == ACC0;
    assign acc1  = state_q == ACC1;

    assign ram_addr  = acc0 ? addr_q[31:2] : acc1 ? addr_q[31:2] + 30'd1 : '0;
    assign ram_we    = we_q && acc0 ? mask8[3:0] : we_q && acc1 ? mask8[7:4] : 4'b0000;
    assign ram_wdata = we_q && acc0 ? w64[31:0] : we_q && acc1 ? w64[63:32] : '0;
    assign ram_re    = !we_q && (acc0 || acc1);

    // load assembly: in FIN the live read data is the only word (aligned) or the upper word (split)
    assign hi  = split_q ? ram_rdata : '0;
    assign lo  = split_q ? lo_q : ram_rdata;
    assign sh  = 32'({hi, lo} >> {off, 3'b000});
    assign sgn = ~mode_q[2];
    assign ext = mode_q[1:0] == 2'b00 ? {{24{sgn & sh[7]}}, sh[7:0]} :
                 mode_q[1:0] == 2'b01 ? {{16{sgn & sh[15]}}, sh[15:0]} : sh;

    assign req_ready = state_q == IDLE && !rst;
    assign rsp_valid = state_q == RESP;
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rdata_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = accept ? (illegal ? RESP : ACC0) : IDLE;
            ACC0:    state_d = split_q ? ACC1 : FIN;
            ACC1:    state_d = FIN;
            FIN:     state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
            mode_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                mode_q  <= req_mode;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                split_q <= split_req;
                err_q   <= illegal;
                if (illegal) rdata_q <= '0;
            end
            if (acc1) lo_q <= ram_rdata;
            if (state_q == FIN) rdata_q <= we_q ? '0 : ext;
        end
    end
endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: scoreboard bench for ram_ctrl with a byte-lane RAM model.
module tb_ram_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 0, req_we = 0, req_ready, rsp_valid, rsp_err, ram_re;
    logic [2:0]  req_mode = 0;
    logic [31:0] req_addr = 0, req_wdata = 0, rsp_rdata, ram_wdata, ram_rdata = 0;
    logic [29:0] ram_addr;
    logic [3:0]  ram_we;

    logic        req_valid1 = 0, req_we1 = 0, req_ready1, rsp_valid1, rsp_err1, ram_re1;
    logic [2:0]  req_mode1 = 0;
    logic [31:0] req_addr1 = 0, req_wdata1 = 0, rsp_rdata1, ram_wdata1;
    logic [29:0] ram_addr1;
    logic [3:0]  ram_we1;

    ram_ctrl u0 (.clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
                 .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
                 .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .ram_addr(ram_addr), .ram_we(ram_we),
                 .ram_re(ram_re), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

    ram_ctrl #(.MISALIGN_EN(1'b0)) u1 (.clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
                 .req_we(req_we1), .req_mode(req_mode1), .req_addr(req_addr1), .req_wdata(req_wdata1),
                 .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1), .ram_addr(ram_addr1),
                 .ram_we(ram_we1), .ram_re(ram_re1), .ram_wdata(ram_wdata1), .ram_rdata(32'h0));

    int checks = 0, fails = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {logic [31:0] rd; logic err; int c0; int lat;} rsp_t;
    typedef struct packed {logic [29:0] addr; logic [3:0] we; logic [31:0] wdata; logic re;} beat_t;
    rsp_t  rq[$], rq1[$];
    beat_t bq[$];

    function automatic void chk(string n, logic [66:0] a, logic [66:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
        end
    endfunction

    // RAM model: synchronous read, per-lane write
    logic [31:0] mem [logic [29:0]];
    always @(posedge clk) begin
        logic [31:0] w;
        w = mem.exists(ram_addr) ? mem[ram_addr] : 32'h0;
        if (ram_re) ram_rdata <= w;
        if (ram_we != 0) begin
            for (int i = 0; i < 4; i++) if (ram_we[i]) w[8*i +: 8] = ram_wdata[8*i +: 8];
            mem[ram_addr] = w;
        end
    end

    // monitors
    always @(negedge clk) begin
        if (rsp_valid) begin
            rsp_t e;
            if (rq.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
                e = rq.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rd);
                chk("rsp_err", rsp_err, e.err);
                chk("rsp_latency", cyc - e.c0, e.lat);
            end
        end
        if (ram_we != 0 || ram_re) begin
            if (bq.size() == 0) chk("ram_beat_unexpected", {ram_addr, ram_we, ram_wdata, ram_re}, 0);
            else chk("ram_beat", {ram_addr, ram_we, ram_wdata, ram_re}, bq.pop_front());
        end
        if (rsp_valid1) begin
            rsp_t e;
            if (rq1.size() == 0) chk("rsp1_unexpected", 1, 0);
            else begin
                e = rq1.pop_front();
                chk("rsp1_rdata", rsp_rdata1, e.rd);
                chk("rsp1_err", rsp_err1, e.err);
                chk("rsp1_latency", cyc - e.c0, e.lat);
            end
        end
        if (ram_we1 != 0 || ram_re1) chk("ram1_activity", {ram_we1, ram_re1}, 0);
    end

    task automatic beat(input logic [29:0] a, input logic [3:0] we, input logic [31:0] wd, input logic re);
        bq.push_back({a, we, wd, re});
    endtask

    task automatic issue(input bit sel, input logic we, input logic [2:0] mode, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rd, input logic err, input int lat);
        int n = 0;
        @(negedge clk);
        while (!(sel ? req_ready1 : req_ready) && n < 20) begin @(negedge clk); n++; end
        chk("req_ready_before_issue", sel ? req_ready1 : req_ready, 1);
        if (sel) begin
            req_we1 = we; req_mode1 = mode; req_addr1 = addr; req_wdata1 = wdata; req_valid1 = 1;
            rq1.push_back('{rd, err, cyc, lat});
        end else begin
            req_we = we; req_mode = mode; req_addr = addr; req_wdata = wdata; req_valid = 1;
            rq.push_back('{rd, err, cyc, lat});
        end
        @(posedge clk);
        #1 req_valid = 0; req_valid1 = 0;
        repeat (lat + 1) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        mem[30'd1] = 32'hAABBCCDD;
        mem[30'd2] = 32'h11223380;
        mem[30'h3FFFFFFF] = 32'h12345678;
        mem[30'd0] = 32'h9ABCDEF0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_outputs", {rsp_valid, rsp_err, ram_we, ram_re, ram_addr, ram_wdata, rsp_rdata}, 0);
        rst = 0;
        @(negedge clk);
        chk("ready_after_reset", req_ready, 1);

        // loads: aligned and split, signed and unsigned
        beat(1, 0, 0, 1); beat(2, 0, 0, 1); issue(0, 0, 3'b001, 32'h7, 0, 32'hFFFF80AA, 0, 4);
        beat(1, 0, 0, 1); beat(2, 0, 0, 1); issue(0, 0, 3'b101, 32'h7, 0, 32'h000080AA, 0, 4);
        beat(1, 0, 0, 1); issue(0, 0, 3'b000, 32'h5, 0, 32'hFFFFFFCC, 0, 3);
        beat(1, 0, 0, 1); issue(0, 0, 3'b100, 32'h5, 0, 32'h000000CC, 0, 3);
        beat(1, 0, 0, 1); issue(0, 0, 3'b010, 32'h4, 0, 32'hAABBCCDD, 0, 3);
        beat(1, 0, 0, 1); issue(0, 0, 3'b001, 32'h4, 0, 32'hFFFFCCDD, 0, 3);
        beat(1, 0, 0, 1); beat(2, 0, 0, 1); issue(0, 0, 3'b010, 32'h6, 0, 32'h3380AABB, 0, 4);
        beat(30'h3FFFFFFF, 0, 0, 1); beat(0, 0, 0, 1);
        issue(0, 0, 3'b010, 32'hFFFFFFFE, 0, 32'hDEF01234, 0, 4);

        // stores, then read back the merged words
        beat(1, 4'b1100, 32'h33440000, 0); beat(2, 4'b0011, 32'h00001122, 0);
        issue(0, 1, 3'b010, 32'h6, 32'h11223344, 0, 0, 4);
        beat(1, 4'b0100, 32'h005A0000, 0); issue(0, 1, 3'b000, 32'h6, 32'h5A, 0, 0, 3);
        beat(0, 4'b1000, 32'hEF000000, 0); beat(1, 4'b0001, 32'h000000BE, 0);
        issue(0, 1, 3'b001, 32'h3, 32'hBEEF, 0, 0, 4);
        beat(0, 0, 0, 1); issue(0, 0, 3'b010, 32'h0, 0, 32'hEFBCDEF0, 0, 3);
        beat(1, 0, 0, 1); issue(0, 0, 3'b010, 32'h4, 0, 32'h335ACCBE, 0, 3);
        beat(2, 0, 0, 1); issue(0, 0, 3'b010, 32'h8, 0, 32'h11221122, 0, 3);

        // illegal requests: no RAM beats, rdata cleared
        issue(0, 0, 3'b011, 32'h0, 0, 0, 1, 1);
        issue(0, 1, 3'b100, 32'h4, 32'hFF, 0, 1, 1);
        issue(0, 0, 3'b111, 32'h8, 0, 0, 1, 1);
        issue(1, 0, 3'b010, 32'h2, 0, 0, 1, 1);
        issue(1, 0, 3'b001, 32'h3, 0, 0, 1, 1);

        // reset during ACC1 of a split store: only the first word is written
        @(negedge clk);
        chk("ready_before_abort", req_ready, 1);
        beat(1, 4'b1100, 32'hF00D0000, 0);
        req_we = 1; req_mode = 3'b010; req_addr = 32'h6; req_wdata = 32'hCAFEF00D; req_valid = 1;
        @(posedge clk);
        #1 req_valid = 0;
        @(posedge clk);
        #2 rst = 1;
        #1 chk("abort_ram_we", ram_we, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        chk("ready_in_reset", req_ready, 0);
        rst = 0;
        @(negedge clk);
        chk("ready_after_abort", req_ready, 1);
        beat(1, 0, 0, 1); issue(0, 0, 3'b010, 32'h4, 0, 32'hF00DCCBE, 0, 3);

        repeat (5) @(negedge clk);
        chk("rsp_queue_drained", rq.size(), 0);
        chk("rsp1_queue_drained", rq1.size(), 0);
        chk("beat_queue_drained", bq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Load/store sequencer between the core's memory stage and the byte-lane data RAM (synchronous read, per-byte write enables, 30-bit word address). Accepts one request at a time with a valid/ready handshake. Decodes RISC-V funct3 width/sign, generates byte enables and lane-shifted write data, and splits misaligned halfword/word accesses into two consecutive word accesses. Returns load data sign- or zero-extended with a one-cycle response pulse.

## Interface
- MISALIGN_EN, 1, 1 = split misaligned accesses into two RAM cycles; 0 = reject them with rsp_err
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller idle; a request is accepted on req_valid && req_ready at a rising edge
- req_we  in  1  1 = store, 0 = load
- req_mode  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are illegal; BU/HU are illegal for stores
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data (0 for stores and errors), held until the next response
- rsp_err  out  1  illegal mode or rejected misalignment; valid with rsp_valid
- ram_addr  out  30  RAM word address
- ram_we  out  4  byte-lane write enables; lane i = bits [8i+7:8i]
- ram_re  out  1  read strobe
- ram_wdata  out  32  lane-aligned write data; 0 when ram_we == 0
- ram_rdata  in  32  read data, valid the cycle after ram_re

## Operation
- FSM states: IDLE, ACC0, ACC1, FIN, RESP.
- IDLE: req_ready = 1. On accept, latch we, mode, addr and wdata. Illegal request → RESP with err = 1, no RAM access. Otherwise → ACC0.
- off = addr[1:0]; widthB = 1/2/4. A request is split when off + widthB > 4 (H at off 3; W at off ≠ 0).
- If split and MISALIGN_EN = 0, the request is treated as illegal.
- ACC0: ram_addr = addr[31:2].
  - Store: ram_we = (mask << off)[3:0], ram_wdata = (wdata << 8·off)[31:0]. mask is 0001/0011/1111.
  - Load: ram_re = 1.
  - Next state: ACC1 if split, else FIN.
- ACC1: ram_addr = addr[31:2] + 1, wrapping modulo 2^30.
  - Store: ram_we = (mask << off)[7:4], ram_wdata = wdata >> 8·(4 − off).
  - Load: ram_re = 1; capture ram_rdata into lo.
  - Next state: FIN.
- FIN: no RAM access. Capture ram_rdata (into hi if split, else lo) and register rsp_rdata:
  - Form a 64-bit value {hi, lo}; if not split, hi = 0.
  - Shift it right by 8·off and keep widthB bytes.
  - Sign-extend for B/H; zero-extend for BU/HU/W. Stores give 0.
  - Next state: RESP.
- RESP: rsp_valid = 1 for one cycle. rsp_err = 1 only on the error path. Next state: IDLE.
- ram_we = 0 and ram_re = 0 in every state other than ACC0/ACC1.

## Timing
- Handshake in cycle 0. An aligned request is in ACC0 in cycle 1, FIN in cycle 2, RESP in cycle 3. A split request inserts ACC1, so RESP is in cycle 4. Stores have the same latency as loads.
- Error path: RESP in cycle 1.
- Back-to-back: req_ready returns 1 in the cycle after RESP. Throughput is at most one request per 4 (aligned) or 5 (split) cycles.
- req_* inputs are ignored while req_ready = 0; no request queuing.
- Reset asserted, including mid-access:
  - State is IDLE immediately. ram_we = 0, ram_re = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, ram_addr = 0, ram_wdata = 0.
  - req_ready = 0 while rst is high and 1 after release.
  - A store interrupted between ACC0 and ACC1 may leave only its first word written; no response is issued.

## Test plan
- SW 0x11223344 at 0x6, MISALIGN_EN = 1 → ACC0: ram_addr 1, ram_we 1100, ram_wdata 0x33440000. ACC1: ram_addr 2, ram_we 0011, ram_wdata 0x00001122. rsp_valid 4 cycles after accept, err 0.
- RAM word1 = 0xAABBCCDD, word2 = 0x11223380; LH at 0x7 → rsp_rdata 0xFFFF80AA. LHU at 0x7 → 0x000080AA. Each in 4 cycles.
- word1 = 0xAABBCCDD:
  - LB at 0x5 → 0xFFFFFFCC; LBU → 0x000000CC; LW at 0x4 → 0xAABBCCDD, each rsp_valid 3 cycles after accept.
  - SB 0x5A at 0x6 → ram_we 0100, ram_wdata 0x005A0000.
- Mode 011, or LBU with req_we = 1, or LW at 0x2 with MISALIGN_EN = 0 → rsp_valid 1 cycle after accept, rsp_err 1, rsp_rdata 0, no ram_we/ram_re pulses.
- LW at 0xFFFFFFFE → ram_addr 0x3FFFFFFF then 0x00000000; data assembled from both words.
- Reset asserted during ACC1 of a split store → ram_we drops to 0 asynchronously, no rsp_valid. After release req_ready = 1 and a new aligned LW completes in 3 cycles.
